// File: rtl/seq_detect_prog.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_prog
// Purpose  : Serial bit-stream detector with a runtime-programmable pattern
//            of 1..MAX_LEN bits, overlap mode, Mealy/registered match outputs
//            and a saturating match counter.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_prog #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               x,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pattern_in,
    input  logic [LEN_W-1:0]   len_in,
    input  logic               overlap_in,
    input  logic               cnt_clr,
    output logic               match,
    output logic               match_q,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err
);

    localparam logic [LEN_W-1:0] c_max_fill = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;

    logic [MAX_LEN-1:0] w_mask;
    logic [MAX_LEN-1:0] w_cand;
    logic               w_fill_ok;
    logic               w_cnt_sat;
    logic               w_len_bad;

    // Only the low r_len bits of candidate and pattern take part in the compare.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (LEN_W'(i) < r_len);
        end
    end

    assign w_cand    = {r_hist[MAX_LEN-2:0], x};
    assign w_fill_ok = (({1'b0, r_fill} + (LEN_W + 1)'(1)) >= {1'b0, r_len});
    assign w_cnt_sat = &match_cnt;
    assign w_len_bad = (len_in == '0) || (len_in > c_max_fill);

    assign match = rst && en && !cfg_load && !cfg_err && w_fill_ok
                   && ((w_cand & w_mask) == (r_pattern & w_mask));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist    <= '0;
            r_fill    <= '0;
            r_pattern <= '0;
            r_len     <= '0;
            r_overlap <= 1'b1;
            cfg_err   <= 1'b1;
            match_q   <= 1'b0;
            match_cnt <= '0;
        end else begin
            match_q <= match;

            if (cnt_clr) begin
                match_cnt <= '0;
            end else if (match && !w_cnt_sat) begin
                match_cnt <= match_cnt + 1'b1;
            end

            if (cfg_load) begin
                r_pattern <= pattern_in;
                r_len     <= len_in;
                r_overlap <= overlap_in;
                cfg_err   <= w_len_bad;
                r_hist    <= '0;
                r_fill    <= '0;
            end else if (en) begin
                // Non-overlapping mode restarts from an empty history after a hit.
                if (match && !r_overlap) begin
                    r_hist <= '0;
                    r_fill <= '0;
                end else begin
                    r_hist <= {r_hist[MAX_LEN-2:0], x};
                    if (r_fill != c_max_fill) begin
                        r_fill <= r_fill + 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detect_prog
// Purpose  : Scoreboard bench for seq_detect_prog (MAX_LEN=8, CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detect_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       x = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] pattern_in = '0;
    logic [3:0] len_in = '0;
    logic       overlap_in = 1'b1;
    logic       cnt_clr = 1'b0;
    logic       match;
    logic       match_q;
    logic [1:0] match_cnt;
    logic       cfg_err;

    seq_detect_prog #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .x          (x),
        .cfg_load   (cfg_load),
        .pattern_in (pattern_in),
        .len_in     (len_in),
        .overlap_in (overlap_in),
        .cnt_clr    (cnt_clr),
        .match      (match),
        .match_q    (match_q),
        .match_cnt  (match_cnt),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       m;
        logic       mq;
        logic [1:0] cnt;
        logic       err;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: what the outputs must show in the next driven cycle.
    logic       m_pm  = 1'b0;
    logic [1:0] m_cnt = '0;
    logic       m_err = 1'b1;

    task automatic drive(input logic r, input logic e, input logic b, input logic cl,
                         input logic cc, input logic m, input string tag);
        exp_t ex;
        @(negedge clk);
        rst = r; en = e; x = b; cfg_load = cl; cnt_clr = cc;
        if (!r) begin
            ex = '{m: 1'b0, mq: 1'b0, cnt: 2'd0, err: 1'b1, tag: tag};
            m_pm = 1'b0; m_cnt = '0; m_err = 1'b1;
        end else begin
            ex = '{m: m, mq: m_pm, cnt: m_cnt, err: m_err, tag: tag};
            if (cc) m_cnt = '0;
            else if (m && m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
            m_pm = m;
            if (cl) m_err = (len_in == 4'd0) || (len_in > 4'd8);
        end
        exp_q.push_back(ex);
    endtask

    task automatic run(input logic [31:0] bits, input logic [31:0] mask,
                       input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) drive(1'b1, 1'b1, bits[i], 1'b0, 1'b0, mask[i], tag);
    endtask

    // Loads config with en=1, x=1 on the line to show that sample is dropped.
    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic ov, input logic cc);
        pattern_in = p; len_in = l; overlap_in = ov;
        drive(1'b1, 1'b1, 1'b1, 1'b1, cc, 1'b0, "cfg");
    endtask

    task automatic chk(input string tag, input string what, input logic [7:0] got,
                       input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s %s: got %0d expected %0d at %0t", tag, what, got, want, $time);
        end
    endtask

    initial begin : monitor
        exp_t ex;
        forever begin
            @(negedge clk);
            #2;
            while (exp_q.size() > 0) begin
                ex = exp_q.pop_front();
                chk(ex.tag, "match",     {7'd0, match},     {7'd0, ex.m});
                chk(ex.tag, "match_q",   {7'd0, match_q},   {7'd0, ex.mq});
                chk(ex.tag, "match_cnt", {6'd0, match_cnt}, {6'd0, ex.cnt});
                chk(ex.tag, "cfg_err",   {7'd0, cfg_err},   {7'd0, ex.err});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");

        cfg(8'b1011, 4'd4, 1'b1, 1'b1);
        run(32'b011011000101101101001, 32'b000001000000100100000, 21, "ovl_long");
        cfg(8'b1011, 4'd4, 1'b0, 1'b1);
        run(32'b011011000101101101001, 32'b000001000000100000000, 21, "novl_long");

        cfg(8'b1011, 4'd4, 1'b1, 1'b1);
        run(32'b1011011, 32'b0001001, 7, "ovl_short");
        cfg(8'b1011, 4'd4, 1'b0, 1'b1);
        run(32'b1011011, 32'b0001000, 7, "novl_short");

        cfg(8'b1111_1101, 4'd1, 1'b1, 1'b1);
        run(32'b11111, 32'b11111, 5, "len1_sat");
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "clr_vs_match");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");

        cfg(8'h00, 4'd0, 1'b1, 1'b1);
        run(32'hFF, 32'h0, 8, "len0_ones");
        run(32'h00, 32'h0, 8, "len0_zeros");
        cfg(8'hFF, 4'd9, 1'b1, 1'b1);
        run(32'hFF, 32'h0, 8, "len9_ones");
        cfg(8'hFF, 4'd8, 1'b1, 1'b1);
        run(32'hFF, 32'h01, 8, "len8_ones");

        cfg(8'b1011, 4'd4, 1'b1, 1'b0);
        run(32'b101, 32'b000, 3, "pre_rst");
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "mid_rst");
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "mid_rst");
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "post_rst");

        cfg(8'b1011, 4'd4, 1'b1, 1'b1);
        run(32'b101, 32'b000, 3, "pre_cfg");
        cfg(8'b1011, 4'd4, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "post_cfg");
        run(32'b011, 32'b001, 3, "resume");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");

        @(negedge clk);
        #5;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
